core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Parametrised N-master to 1-slave memory arbiter using the core's RAM request protocol: req, write, wstrb, addr, wdata, ready, rvalid, rdata.
- Lets the IF and MEM stages, plus optional extra masters such as a debug or DMA port, share one unified RAM port.
- Supports fixed-priority or round-robin arbitration.
- Holds the grant stable while a request is stalled, and routes in-order read responses back to the issuing master through an outstanding-read tracking FIFO.

Parameters:
- NUM_MASTERS, 2: number of requesting masters, 2..8; index 0 is highest priority in fixed mode.
- XLEN, 32: address/data width; wstrb width is XLEN/8.
- MAX_OUTSTANDING, 4: depth of the read tracking FIFO; power of 2, 2..16.
- ARB_MODE, 1: 0 = fixed priority, 1 = round robin.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset; asynchronous, active-high (asserted when 1)
- m_req  in  NUM_MASTERS  per-master request
- m_write  in  NUM_MASTERS  per-master write (1) / read (0)
- m_wstrb  in  NUM_MASTERS*XLEN/8  packed byte strobes; master i at [i*XLEN/8 +: XLEN/8]
- m_addr  in  NUM_MASTERS*XLEN  packed addresses
- m_wdata  in  NUM_MASTERS*XLEN  packed write data
- m_ready  out  NUM_MASTERS  per-master request accepted
- m_rvalid  out  NUM_MASTERS  per-master read response valid
- m_rdata  out  XLEN  read data, shared across masters, qualified by m_rvalid
- s_req, s_write, s_wstrb, s_addr, s_wdata  out  1,1,XLEN/8,XLEN,XLEN  slave request
- s_ready  in  1  slave accepts request
- s_rvalid  in  1  slave read response
- s_rdata  in  XLEN  slave read data
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  number of reads in flight
- err_rvalid  out  1  sticky: s_rvalid arrived with no read outstanding

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - Round-robin pointer = 0; lock = 0; FIFO empty; outstanding = 0; err_rvalid = 0.
  - All m_ready, m_rvalid, s_req are 0 while reset is asserted.
- Acceptance: a transfer is accepted when s_req & s_ready. A master holds req and its payload until its m_ready.
- Grant selection, combinational from m_req:
  - Fixed mode: lowest index wins.
  - Round-robin mode: first requester at or after the pointer, wrapping at NUM_MASTERS-1 -> 0.
- Lock:
  - If s_req=1 and s_ready=0, the current grant is registered and held on the following cycles until acceptance. Higher-priority requests arriving meanwhile do not preempt it.
  - Lock clears in the cycle after acceptance.
- Output mux: s_write, s_wstrb, s_addr and s_wdata follow the granted master; they are don't-care when s_req=0.
- Read gating: s_req = (any m_req) & !(granted op is read & FIFO full). A write is never blocked by a full FIFO.
- Ready: m_ready[g] = s_ready & s_req for granted g; all other m_ready bits are 0. Zero added latency.
- Pointer update: in round-robin mode, on each acceptance the pointer becomes g+1 mod NUM_MASTERS. There is no update without acceptance.
- Tracking FIFO:
  - On an accepted read, the granted index is pushed.
  - On s_rvalid, the head is popped; m_rvalid[head] = 1 in the same cycle, combinationally, and m_rdata = s_rdata.
  - Writes are not tracked and produce no response.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both take effect.
  - When full, the full flag comes from the registered count (no same-cycle pop bypass), so a read stalls one cycle.
- s_rvalid with FIFO empty: response dropped, all m_rvalid = 0, err_rvalid set to 1 until reset.
- outstanding equals the registered FIFO count.
- Reset mid-transaction: FIFO and lock are cleared. Responses arriving after reset with an empty FIFO set err_rvalid. The slave must be reset alongside.

Test Plan:
- Single master, NUM_MASTERS=2: m_req=01 read addr 0x100, s_ready=1 -> s_req=1, s_addr=0x100, m_ready=01 same cycle. s_rvalid 2 cycles later with rdata 0xDEADBEEF -> m_rvalid=01, m_rdata=0xDEADBEEF, outstanding returns 1 -> 0.
- Round robin: both masters request continuously, s_ready=1 -> grants alternate 0,1,0,1. With ARB_MODE=0 -> master 0 granted every cycle and m_ready[1]=0.
- Lock: master 1 alone requests, s_ready=0 for 3 cycles, master 0 raises req in cycle 2 -> s_addr stays master 1's. Acceptance goes to master 1, then master 0 next cycle.
- Full FIFO, MAX_OUTSTANDING=4: issue 4 reads with no s_rvalid -> outstanding=4 and the 5th read sees s_req=0. A write from the other master is still accepted. One s_rvalid -> the 5th read is accepted the next cycle.
- Ordering: reads by master 0, 1, 1, 0, then 4 s_rvalid pulses -> m_rvalid sequence 01,10,10,01. Push and pop in the same cycle leaves outstanding unchanged.
- Error and reset: s_rvalid with outstanding=0 -> err_rvalid=1 and sticky, no m_rvalid. Assert rst_b with 2 reads outstanding -> outstanding=0, err_rvalid=0, pointer=0.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// N-master to 1-slave RAM port arbiter with fixed-priority or round-robin grant,
// stall-time grant lock and an in-order read tracking FIFO for response routing.
module core_mem_arbiter #(
   parameter int NUM_MASTERS     = 2,
   parameter int XLEN            = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ARB_MODE        = 1
) (
   input  logic                            clk,
   input  logic                            rst_b,
   input  logic [NUM_MASTERS-1:0]          m_req,
   input  logic [NUM_MASTERS-1:0]          m_write,
   input  logic [NUM_MASTERS*XLEN/8-1:0]   m_wstrb,
   input  logic [NUM_MASTERS*XLEN-1:0]     m_addr,
   input  logic [NUM_MASTERS*XLEN-1:0]     m_wdata,
   output logic [NUM_MASTERS-1:0]          m_ready,
   output logic [NUM_MASTERS-1:0]          m_rvalid,
   output logic [XLEN-1:0]                 m_rdata,
   output logic                            s_req,
   output logic                            s_write,
   output logic [XLEN/8-1:0]               s_wstrb,
   output logic [XLEN-1:0]                 s_addr,
   output logic [XLEN-1:0]                 s_wdata,
   input  logic                            s_ready,
   input  logic                            s_rvalid,
   input  logic [XLEN-1:0]                 s_rdata,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
   output logic                            err_rvalid
);

   localparam int SW = XLEN / 8;
   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int AW = $clog2(MAX_OUTSTANDING);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] lock_idx;
   logic          lock;
   logic [IW-1:0] arb_idx;
   logic [IW-1:0] grant;
   logic          g_write;
   logic          accept;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [IW-1:0] fifo_mem [MAX_OUTSTANDING];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   // Descending scan so the lowest qualifying offset is the final assignment.
   always_comb begin
      int idx;
      idx     = 0;
      arb_idx = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         if (ARB_MODE == 0) begin
            idx = k;
         end else begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         end
         if (m_req[idx]) arb_idx = IW'(idx);
      end
   end

   assign grant      = lock ? lock_idx : arb_idx;
   assign g_write    = m_write[grant];
   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);

   // Reads wait on the registered count only; writes never touch the FIFO.
   assign s_req   = !rst_b && (|m_req) && !(!g_write && fifo_full);
   assign accept  = s_req && s_ready;
   assign push    = accept && !g_write;
   assign pop     = !rst_b && s_rvalid && !fifo_empty;

   assign s_write = g_write;
   assign s_wstrb = m_wstrb[int'(grant)*SW +: SW];
   assign s_addr  = m_addr[int'(grant)*XLEN +: XLEN];
   assign s_wdata = m_wdata[int'(grant)*XLEN +: XLEN];
   assign m_rdata = s_rdata;
   assign outstanding = count;

   always_comb begin
      m_ready  = '0;
      m_rvalid = '0;
      if (accept) m_ready[grant] = 1'b1;
      if (pop)    m_rvalid[fifo_mem[rd_ptr]] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         rr_ptr     <= '0;
         lock       <= 1'b0;
         lock_idx   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         err_rvalid <= 1'b0;
      end else begin
         if (s_req && !s_ready) begin
            lock     <= 1'b1;
            lock_idx <= grant;
         end else if (accept) begin
            lock <= 1'b0;
         end
         if (accept && ARB_MODE != 0)
            rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (s_rvalid && fifo_empty) err_rvalid <= 1'b1;
      end
   end

   // Tracking storage needs no reset: entries are only read below the count.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= grant;
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: table-driven grant vectors plus hand sequences for
// lock, full FIFO, response ordering and error/reset, with a response scoreboard.
module tb_core_mem_arbiter;

   localparam int N  = 2;
   localparam int XL = 32;
   localparam int MO = 4;

   logic            clk;
   logic            rst_b;
   logic [N-1:0]    m_req;
   logic [N-1:0]    m_write;
   logic [N*XL/8-1:0] m_wstrb;
   logic [N*XL-1:0] m_addr;
   logic [N*XL-1:0] m_wdata;
   logic            s_ready;
   logic            s_rvalid;
   logic [XL-1:0]   s_rdata;

   logic [N-1:0]    m_ready, m_rvalid;
   logic [XL-1:0]   m_rdata;
   logic            s_req, s_write;
   logic [XL/8-1:0] s_wstrb;
   logic [XL-1:0]   s_addr, s_wdata;
   logic [$clog2(MO):0] outstanding;
   logic            err_rvalid;

   logic [N-1:0]    fx_m_ready, fx_m_rvalid;
   logic [XL-1:0]   fx_m_rdata;
   logic            fx_s_req, fx_s_write;
   logic [XL/8-1:0] fx_s_wstrb;
   logic [XL-1:0]   fx_s_addr, fx_s_wdata;
   logic [$clog2(MO):0] fx_outstanding;
   logic            fx_err_rvalid;

   core_mem_arbiter #(.NUM_MASTERS(N), .XLEN(XL), .MAX_OUTSTANDING(MO), .ARB_MODE(1)) dut (
      .clk(clk), .rst_b(rst_b), .m_req(m_req), .m_write(m_write), .m_wstrb(m_wstrb),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid),
      .m_rdata(m_rdata), .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready), .s_rvalid(s_rvalid),
      .s_rdata(s_rdata), .outstanding(outstanding), .err_rvalid(err_rvalid)
   );

   core_mem_arbiter #(.NUM_MASTERS(N), .XLEN(XL), .MAX_OUTSTANDING(MO), .ARB_MODE(0)) dut_fx (
      .clk(clk), .rst_b(rst_b), .m_req(m_req), .m_write(m_write), .m_wstrb(m_wstrb),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(fx_m_ready), .m_rvalid(fx_m_rvalid),
      .m_rdata(fx_m_rdata), .s_req(fx_s_req), .s_write(fx_s_write), .s_wstrb(fx_s_wstrb),
      .s_addr(fx_s_addr), .s_wdata(fx_s_wdata), .s_ready(s_ready), .s_rvalid(s_rvalid),
      .s_rdata(s_rdata), .outstanding(fx_outstanding), .err_rvalid(fx_err_rvalid)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [N+XL-1:0] exp_q[$];

   typedef struct {
      logic [N-1:0]  req;
      logic [N-1:0]  wr;
      logic          rdy;
      logic          exp_sreq;
      logic [N-1:0]  exp_rdy;
      logic [N-1:0]  exp_fx_rdy;
      logic [XL-1:0] exp_addr;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_b    = 1'b1;
      m_req    = '0;
      m_write  = '0;
      s_ready  = 1'b0;
      s_rvalid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b0;
   endtask

   task automatic set_addr(input int m, input logic [XL-1:0] a);
      m_addr[m*XL +: XL] = a;
   endtask

   // One-cycle read by master m alone; the slave will later answer with data.
   task automatic issue_read(input int m, input logic [XL-1:0] a, input logic [XL-1:0] data);
      logic [N-1:0] oh;
      oh      = '0;
      oh[m]   = 1'b1;
      m_req   = oh;
      m_write = '0;
      s_ready = 1'b1;
      set_addr(m, a);
      @(negedge clk);
      chk("rd_s_req", s_req, 1'b1);
      chk("rd_m_ready", m_ready, oh);
      chk("rd_s_addr", s_addr, a);
      exp_q.push_back({oh, data});
      cyc();
      m_req   = '0;
      s_ready = 1'b0;
   endtask

   task automatic drive_resp();
      logic [N+XL-1:0] e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL resp_underflow: got response slot, expected none queued");
      end else begin
         e        = exp_q.pop_front();
         s_rvalid = 1'b1;
         s_rdata  = e[XL-1:0];
         @(negedge clk);
         chk("resp_m_rvalid", m_rvalid, e[XL +: N]);
         chk("resp_m_rdata", m_rdata, e[XL-1:0]);
         cyc();
         s_rvalid = 1'b0;
      end
   endtask

   initial begin
      logic [N+XL-1:0] e;
      tbl[0] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 32'hA0};
      tbl[1] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 32'hB0};
      tbl[2] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 32'hA0};
      tbl[3] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 32'hB0};
      tbl[4] = '{2'b10, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, 32'hB0};
      tbl[5] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0};
      tbl[6] = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b00, 2'b00, 32'hA0};
      tbl[7] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 32'hA0};
      tbl[8] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 32'hB0};

      rst_b    = 1'b1;
      m_req    = 2'b11;
      m_write  = 2'b00;
      m_wstrb  = '1;
      m_addr   = '0;
      m_wdata  = '0;
      s_ready  = 1'b1;
      s_rvalid = 1'b1;
      s_rdata  = 32'h1234_5678;
      #3;
      chk("rst_s_req", s_req, 1'b0);
      chk("rst_m_ready", m_ready, 2'b00);
      chk("rst_m_rvalid", m_rvalid, 2'b00);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err_rvalid, 1'b0);

      // single master read, response two cycles after acceptance
      do_reset();
      issue_read(0, 32'h100, 32'hDEADBEEF);
      chk("t1_outstanding_1", outstanding, 1);
      cyc();
      drive_resp();
      chk("t1_outstanding_0", outstanding, 0);

      // grant table: round robin vs fixed priority, plus a stalled cycle
      do_reset();
      set_addr(0, 32'hA0);
      set_addr(1, 32'hB0);
      for (int i = 0; i < 9; i++) begin
         m_req   = tbl[i].req;
         m_write = tbl[i].wr;
         s_ready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_s_req", i), s_req, tbl[i].exp_sreq);
         chk($sformatf("tbl%0d_m_ready", i), m_ready, tbl[i].exp_rdy);
         chk($sformatf("tbl%0d_fx_m_ready", i), fx_m_ready, tbl[i].exp_fx_rdy);
         if (tbl[i].exp_sreq) chk($sformatf("tbl%0d_s_addr", i), s_addr, tbl[i].exp_addr);
         cyc();
      end
      m_req = '0;

      // lock: master 1 stalled, master 0 arrives and must wait
      do_reset();
      m_req   = 2'b10;
      s_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) m_req = 2'b11;
         @(negedge clk);
         chk("lock_s_addr", s_addr, 32'hB0);
         chk("lock_m_ready", m_ready, 2'b00);
         cyc();
      end
      s_ready = 1'b1;
      @(negedge clk);
      chk("lock_acc_m_ready", m_ready, 2'b10);
      chk("lock_acc_s_addr", s_addr, 32'hB0);
      exp_q.push_back({2'b10, 32'hB0B0_0001});
      cyc();
      m_req = 2'b01;
      @(negedge clk);
      chk("lock_next_m_ready", m_ready, 2'b01);
      chk("lock_next_s_addr", s_addr, 32'hA0);
      exp_q.push_back({2'b01, 32'hA0A0_0002});
      cyc();
      m_req   = '0;
      s_ready = 1'b0;
      chk("lock_outstanding", outstanding, 2);
      drive_resp();
      drive_resp();

      // full FIFO: reads stall, writes pass, one pop frees a slot a cycle later
      do_reset();
      for (int r = 0; r < MO; r++) issue_read(0, 32'h200 + 32'(r * 4), $urandom);
      chk("full_outstanding", outstanding, MO);
      m_req   = 2'b01;
      m_write = 2'b00;
      s_ready = 1'b1;
      @(negedge clk);
      chk("full_rd_s_req", s_req, 1'b0);
      chk("full_rd_m_ready", m_ready, 2'b00);
      cyc();
      m_req   = 2'b11;
      m_write = 2'b10;
      @(negedge clk);
      chk("full_wr_s_req", s_req, 1'b1);
      chk("full_wr_m_ready", m_ready, 2'b10);
      chk("full_wr_s_write", s_write, 1'b1);
      cyc();
      m_req    = 2'b01;
      m_write  = 2'b00;
      e        = exp_q.pop_front();
      s_rvalid = 1'b1;
      s_rdata  = e[XL-1:0];
      @(negedge clk);
      chk("full_pop_s_req", s_req, 1'b0);
      chk("full_pop_m_rvalid", m_rvalid, e[XL +: N]);
      chk("full_pop_m_rdata", m_rdata, e[XL-1:0]);
      cyc();
      s_rvalid = 1'b0;
      @(negedge clk);
      chk("full_retry_m_ready", m_ready, 2'b01);
      exp_q.push_back({2'b01, 32'hF00D_0005});
      cyc();
      m_req   = '0;
      s_ready = 1'b0;
      chk("full_refill", outstanding, MO);
      for (int r = 0; r < MO; r++) drive_resp();
      chk("full_drained", outstanding, 0);

      // ordering 0,1,1,0 with a same-cycle push and pop in the middle
      do_reset();
      issue_read(0, 32'h300, $urandom);
      issue_read(1, 32'h304, $urandom);
      m_req    = 2'b10;
      m_write  = 2'b00;
      s_ready  = 1'b1;
      set_addr(1, 32'h308);
      e        = exp_q.pop_front();
      s_rvalid = 1'b1;
      s_rdata  = e[XL-1:0];
      exp_q.push_back({2'b10, 32'hCAFE_0003});
      @(negedge clk);
      chk("ord_pp_m_ready", m_ready, 2'b10);
      chk("ord_pp_m_rvalid", m_rvalid, e[XL +: N]);
      chk("ord_pp_m_rdata", m_rdata, e[XL-1:0]);
      cyc();
      m_req    = '0;
      s_ready  = 1'b0;
      s_rvalid = 1'b0;
      chk("ord_pp_outstanding", outstanding, 2);
      issue_read(0, 32'h30C, $urandom);
      for (int r = 0; r < 3; r++) drive_resp();
      chk("ord_outstanding", outstanding, 0);

      // stray response, sticky error, reset with reads in flight
      do_reset();
      s_rvalid = 1'b1;
      @(negedge clk);
      chk("err_m_rvalid", m_rvalid, 2'b00);
      cyc();
      s_rvalid = 1'b0;
      chk("err_set", err_rvalid, 1'b1);
      cyc();
      cyc();
      chk("err_sticky", err_rvalid, 1'b1);
      issue_read(0, 32'h400, $urandom);
      issue_read(0, 32'h404, $urandom);
      chk("pre_rst_outstanding", outstanding, 2);
      rst_b = 1'b1;
      exp_q.delete();
      #2;
      chk("mid_rst_outstanding", outstanding, 0);
      chk("mid_rst_err", err_rvalid, 1'b0);
      cyc();
      rst_b    = 1'b0;
      s_rvalid = 1'b1;
      @(negedge clk);
      chk("post_rst_m_rvalid", m_rvalid, 2'b00);
      cyc();
      s_rvalid = 1'b0;
      chk("post_rst_err", err_rvalid, 1'b1);
      m_req   = 2'b11;
      m_write = 2'b11;
      s_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_ptr", m_ready, 2'b01);
      cyc();
      m_req   = '0;
      s_ready = 1'b0;

      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
